op_decode_stage: RTL and testbench
==================================

Name: op_decode_stage

Overview:
- Registered, flow-controlled instruction decode stage for the TIS-100 node. Successor to the combinational decoder.
- Sits between instruction fetch (program memory) and execute (ALU, registers, port muxes).
- Takes one op_code word and produces registered control fields plus a sign-extended immediate.
- Valid/ready handshake on both sides, a 2-entry skid buffer, flush on taken branch, and illegal-opcode detection.

Parameters:
- IMM_WIDTH, 11, immediate field width in op_code.
- DATA_WIDTH, 11, datapath width; imm output is sign-extended to this; must be >= IMM_WIDTH.
- OP_CODE_WIDTH, 10+IMM_WIDTH, derived; layout [op 4 | src 3 | imm IMM_WIDTH | dst 3], MSB first.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- in_valid  in  1  op_code valid from fetch
- in_ready  out  1  stage can accept; registered
- op_code  in  OP_CODE_WIDTH  instruction word
- flush  in  1  taken branch; discard all held instructions
- out_valid  out  1  decoded instruction valid
- out_ready  in  1  execute accepts
- pc_instr  out  4  raw opcode
- alu_instr  out  2  ADD=0, SUB=1, NEG=2; 0 otherwise
- registers_instr  out  2  NONE=0, WRITE=1, SWP=2, SAV=3
- in_mux_sel  out  2  CONST=0, ACC=1, DIR=2
- out_mux_sel  out  1  IN=0, ALU=1
- src  out  3  source target
- dst  out  3  destination target
- imm  out  DATA_WIDTH  sign-extended immediate
- port_rd  out  1  src is a port target (UP..LAST)
- port_wr  out  1  op is MOV and dst is a port target
- illegal  out  1  decoded opcode is 13..15

Behaviour:
- Reset:
  - out_valid=0, skid empty, in_ready=1.
  - All decoded outputs 0, which is a NOP with NONE/CONST selects.
- Decode functions:
  - registers_instr: WRITE for MOV/ADD/SUB/NEG, SWP for SWP, SAV for SAV, NONE otherwise.
  - in_mux_sel: CONST if src=NIL, ACC if src=ACC, DIR otherwise.
  - out_mux_sel: IN for MOV, ALU otherwise.
  - No X outputs for any opcode.
- Transfer rules:
  - Input transfer when in_valid & in_ready.
  - Output transfer when out_valid & out_ready.
  - Latency is 1 cycle: decoded fields appear on the clock edge after input transfer if the output register is free or draining.
- Skid buffer:
  - An input transfer while out_valid=1 and out_ready=0 goes to the skid entry; in_ready falls the next cycle.
  - On the next output transfer, the skid entry moves to the output register and in_ready rises the following cycle.
  - Order is strictly FIFO. With both entries full and out_ready=1, an input transfer is impossible because in_ready=0.
- Simultaneous output transfer and input transfer with skid empty: the new word loads the output register directly; out_valid stays 1 with no bubble.
- Flush:
  - Highest priority. On the next edge out_valid=0, skid empty, in_ready=1.
  - Any input transfer in the flush cycle is dropped.
  - An output transfer in the flush cycle still completes.
- Outputs are held stable while out_valid & !out_ready.
- Reset asserted mid-stream discards all entries immediately (asynchronous).

Optional Feature:
- Macro OP_DECODE_ILLEGAL_TRAP_EN.
- Defined: an illegal opcode reaching the output register sets a sticky trap.
  - in_ready is forced to 0 and the stage holds that instruction with illegal=1.
  - Flush does not clear the trap; only rst does.
- Undefined: the illegal word passes through as a NOP (pc_instr=0, registers_instr=NONE) with illegal=1 for that instruction only. Flow is unaffected.

Decomposition:
- Shared header my_params.vh holds:
  - Opcodes: NOP=0, MOV=1, SWP=2, SAV=3, ADD=4, SUB=5, NEG=6, JMP=7, JEZ=8, JNZ=9, JGZ=10, JLZ=11, JRO=12.
  - Targets: NIL=0, ACC=1, UP=2, DOWN=3, LEFT=4, RIGHT=5, ANY=6, LAST=7.
  - INSTR_ALU_*, INSTR_REG_*, IN_MUX_SEL_*, OUT_MUX_SEL_*.
- One sub-module, op_fields_decode: purely combinational op_code to control-field decode, instantiated once on the input side. Both register entries store its result.

Test Plan:
- After reset, in_valid=1 with MOV src=ACC dst=RIGHT -> next cycle out_valid=1, registers_instr=1, in_mux_sel=1, out_mux_sel=0, port_wr=1, port_rd=0.
- ADD src=NIL imm=11'h7FF with DATA_WIDTH=16 -> imm=16'hFFFF, alu_instr=0, in_mux_sel=0.
- Backpressure: out_ready=0 while issuing SUB then NEG -> SUB held, in_ready=0 from the cycle after NEG. Release out_ready -> SUB, then NEG delivered on consecutive cycles, no loss or duplication.
- Streaming with out_ready=1: 8 back-to-back ops -> 8 outputs on consecutive cycles, in_ready constantly 1.
- Flush with both entries full plus in_valid=1 -> next cycle out_valid=0, in_ready=1; the dropped words never appear.
- Opcode 14:
  - Without the macro: pc_instr=0, illegal=1 for one instruction, flow continues.
  - With the macro: illegal=1 held and in_ready=0 until rst.

Source files
------------

// File: rtl/op_decode_stage_pkg.sv
// op_decode_stage_pkg
//   Shared encodings for the TIS-100 node decode path: opcodes, targets,
//   control-field encodings and the packed control-field record that both
//   register entries of op_decode_stage store.
//   Build option: OP_DECODE_ILLEGAL_TRAP_EN (consumed by op_decode_stage).
package op_decode_stage_pkg;

    // Opcodes
    localparam logic [3:0] OP_NOP = 4'd0;
    localparam logic [3:0] OP_MOV = 4'd1;
    localparam logic [3:0] OP_SWP = 4'd2;
    localparam logic [3:0] OP_SAV = 4'd3;
    localparam logic [3:0] OP_ADD = 4'd4;
    localparam logic [3:0] OP_SUB = 4'd5;
    localparam logic [3:0] OP_NEG = 4'd6;
    localparam logic [3:0] OP_JMP = 4'd7;
    localparam logic [3:0] OP_JEZ = 4'd8;
    localparam logic [3:0] OP_JNZ = 4'd9;
    localparam logic [3:0] OP_JGZ = 4'd10;
    localparam logic [3:0] OP_JLZ = 4'd11;
    localparam logic [3:0] OP_JRO = 4'd12;

    // Targets
    localparam logic [2:0] TGT_NIL   = 3'd0;
    localparam logic [2:0] TGT_ACC   = 3'd1;
    localparam logic [2:0] TGT_UP    = 3'd2;
    localparam logic [2:0] TGT_DOWN  = 3'd3;
    localparam logic [2:0] TGT_LEFT  = 3'd4;
    localparam logic [2:0] TGT_RIGHT = 3'd5;
    localparam logic [2:0] TGT_ANY   = 3'd6;
    localparam logic [2:0] TGT_LAST  = 3'd7;

    localparam logic [1:0] INSTR_ALU_ADD = 2'd0;
    localparam logic [1:0] INSTR_ALU_SUB = 2'd1;
    localparam logic [1:0] INSTR_ALU_NEG = 2'd2;

    localparam logic [1:0] INSTR_REG_NONE  = 2'd0;
    localparam logic [1:0] INSTR_REG_WRITE = 2'd1;
    localparam logic [1:0] INSTR_REG_SWP   = 2'd2;
    localparam logic [1:0] INSTR_REG_SAV   = 2'd3;

    localparam logic [1:0] IN_MUX_SEL_CONST = 2'd0;
    localparam logic [1:0] IN_MUX_SEL_ACC   = 2'd1;
    localparam logic [1:0] IN_MUX_SEL_DIR   = 2'd2;

    localparam logic OUT_MUX_SEL_IN  = 1'b0;
    localparam logic OUT_MUX_SEL_ALU = 1'b1;

    // Immediate is kept outside this record since its width is a parameter.
    typedef struct packed {
        logic [3:0] pc_instr;
        logic [1:0] alu_instr;
        logic [1:0] registers_instr;
        logic [1:0] in_mux_sel;
        logic       out_mux_sel;
        logic [2:0] src;
        logic [2:0] dst;
        logic       port_rd;
        logic       port_wr;
        logic       illegal;
    } ctrl_t;

    // UP..LAST are the neighbour/port targets.
    function automatic logic is_port(input logic [2:0] t);
        return t >= TGT_UP;
    endfunction

endpackage

// File: rtl/op_decode_stage_fields.sv
// op_fields_decode
//   Purely combinational op_code -> control-field decode.
//   op_code layout, MSB first: [op 4 | src 3 | imm IMM_WIDTH | dst 3].
//   Ports:
//     op_code_i  in   instruction word (10+IMM_WIDTH bits)
//     ctrl_o     out  decoded control fields
//     imm_o      out  immediate sign-extended to DATA_WIDTH
module op_fields_decode
    import op_decode_stage_pkg::*;
#(
    parameter int IMM_WIDTH  = 11,
    parameter int DATA_WIDTH = 11
) (
    input  logic [10+IMM_WIDTH-1:0] op_code_i,
    output ctrl_t                   ctrl_o,
    output logic [DATA_WIDTH-1:0]   imm_o
);
    localparam int OCW = 10 + IMM_WIDTH;

    logic [3:0]                  op;
    logic [2:0]                  src;
    logic [2:0]                  dst;
    logic signed [IMM_WIDTH-1:0] imm_f;
    logic                        illegal;
    logic [3:0]                  eff_op;

    assign op      = op_code_i[OCW-1 -: 4];
    assign src     = op_code_i[OCW-5 -: 3];
    assign imm_f   = $signed(op_code_i[IMM_WIDTH+2:3]);
    assign dst     = op_code_i[2:0];
    assign illegal = op > OP_JRO;
    // Illegal opcodes decode exactly like a NOP carrying the same operands.
    assign eff_op  = illegal ? OP_NOP : op;

    assign imm_o = DATA_WIDTH'(imm_f);

    always_comb begin
        ctrl_o          = '0;
        ctrl_o.pc_instr = eff_op;
        ctrl_o.src      = src;
        ctrl_o.dst      = dst;
        ctrl_o.illegal  = illegal;
        ctrl_o.port_rd  = is_port(src);
        ctrl_o.port_wr  = (eff_op == OP_MOV) && is_port(dst);

        case (eff_op)
            OP_SUB:  ctrl_o.alu_instr = INSTR_ALU_SUB;
            OP_NEG:  ctrl_o.alu_instr = INSTR_ALU_NEG;
            default: ctrl_o.alu_instr = INSTR_ALU_ADD;
        endcase

        case (eff_op)
            OP_MOV, OP_ADD, OP_SUB, OP_NEG: ctrl_o.registers_instr = INSTR_REG_WRITE;
            OP_SWP:                         ctrl_o.registers_instr = INSTR_REG_SWP;
            OP_SAV:                         ctrl_o.registers_instr = INSTR_REG_SAV;
            default:                        ctrl_o.registers_instr = INSTR_REG_NONE;
        endcase

        case (src)
            TGT_NIL: ctrl_o.in_mux_sel = IN_MUX_SEL_CONST;
            TGT_ACC: ctrl_o.in_mux_sel = IN_MUX_SEL_ACC;
            default: ctrl_o.in_mux_sel = IN_MUX_SEL_DIR;
        endcase

        ctrl_o.out_mux_sel = (eff_op == OP_MOV) ? OUT_MUX_SEL_IN : OUT_MUX_SEL_ALU;
    end

endmodule

// File: rtl/op_decode_stage.sv
// op_decode_stage
//   Registered, valid/ready decode stage between fetch and execute, with a
//   2-entry (output + skid) buffer, flush on taken branch and illegal-opcode
//   detection. Build option OP_DECODE_ILLEGAL_TRAP_EN: an illegal opcode
//   reaching the output register freezes the stage until rst.
//   Ports:
//     clk, rst              clock, async active-high reset
//     in_valid/in_ready     fetch handshake (in_ready is a flop)
//     op_code               instruction word
//     flush                 taken branch, drops all held words
//     out_valid/out_ready   execute handshake
//     pc_instr..illegal     registered decoded fields, imm sign-extended
module op_decode_stage
    import op_decode_stage_pkg::*;
#(
    parameter int IMM_WIDTH  = 11,
    parameter int DATA_WIDTH = 11
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [10+IMM_WIDTH-1:0] op_code,
    input  logic                    flush,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [3:0]              pc_instr,
    output logic [1:0]              alu_instr,
    output logic [1:0]              registers_instr,
    output logic [1:0]              in_mux_sel,
    output logic                    out_mux_sel,
    output logic [2:0]              src,
    output logic [2:0]              dst,
    output logic [DATA_WIDTH-1:0]   imm,
    output logic                    port_rd,
    output logic                    port_wr,
    output logic                    illegal
);
    ctrl_t                 dec_ctrl;
    logic [DATA_WIDTH-1:0] dec_imm;

    op_fields_decode #(.IMM_WIDTH(IMM_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_dec (
        .op_code_i (op_code),
        .ctrl_o    (dec_ctrl),
        .imm_o     (dec_imm)
    );

    ctrl_t                 out_ctrl_q, out_ctrl_d, skid_ctrl_q, skid_ctrl_d;
    logic [DATA_WIDTH-1:0] out_imm_q, out_imm_d, skid_imm_q, skid_imm_d;
    logic                  out_valid_q, out_valid_d, skid_valid_q, skid_valid_d;
    logic                  in_ready_q, in_ready_d, trap_q, trap_d;
    logic                  in_xfer, out_xfer;

    assign in_xfer  = in_valid & in_ready_q;
    assign out_xfer = out_valid_q & out_ready;

    always_comb begin
        out_ctrl_d   = out_ctrl_q;
        out_imm_d    = out_imm_q;
        skid_ctrl_d  = skid_ctrl_q;
        skid_imm_d   = skid_imm_q;
        out_valid_d  = out_valid_q;
        skid_valid_d = skid_valid_q;
        trap_d       = trap_q;

        if (trap_q) begin
            // Trapped: everything holds until rst.
        end else if (flush) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (out_xfer || !out_valid_q) begin
            // Output register free or draining. A full skid implies
            // in_ready was low, so no input can collide with the refill.
            if (skid_valid_q) begin
                out_ctrl_d   = skid_ctrl_q;
                out_imm_d    = skid_imm_q;
                out_valid_d  = 1'b1;
                skid_valid_d = 1'b0;
            end else if (in_xfer) begin
                out_ctrl_d  = dec_ctrl;
                out_imm_d   = dec_imm;
                out_valid_d = 1'b1;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (in_xfer) begin
            skid_ctrl_d  = dec_ctrl;
            skid_imm_d   = dec_imm;
            skid_valid_d = 1'b1;
        end

`ifdef OP_DECODE_ILLEGAL_TRAP_EN
        trap_d = trap_q | (out_valid_d & out_ctrl_d.illegal);
`endif

        // Registered ready: accept only while the skid entry will be free.
        in_ready_d = !skid_valid_d && !trap_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_ctrl_q   <= '0;
            out_imm_q    <= '0;
            skid_ctrl_q  <= '0;
            skid_imm_q   <= '0;
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
            in_ready_q   <= 1'b1;
            trap_q       <= 1'b0;
        end else begin
            out_ctrl_q   <= out_ctrl_d;
            out_imm_q    <= out_imm_d;
            skid_ctrl_q  <= skid_ctrl_d;
            skid_imm_q   <= skid_imm_d;
            out_valid_q  <= out_valid_d;
            skid_valid_q <= skid_valid_d;
            in_ready_q   <= in_ready_d;
            trap_q       <= trap_d;
        end
    end

    assign in_ready        = in_ready_q;
    assign out_valid       = out_valid_q;
    assign pc_instr        = out_ctrl_q.pc_instr;
    assign alu_instr       = out_ctrl_q.alu_instr;
    assign registers_instr = out_ctrl_q.registers_instr;
    assign in_mux_sel      = out_ctrl_q.in_mux_sel;
    assign out_mux_sel     = out_ctrl_q.out_mux_sel;
    assign src             = out_ctrl_q.src;
    assign dst             = out_ctrl_q.dst;
    assign imm             = out_imm_q;
    assign port_rd         = out_ctrl_q.port_rd;
    assign port_wr         = out_ctrl_q.port_wr;
    assign illegal         = out_ctrl_q.illegal;

endmodule

// File: tb/tb_op_decode_stage.sv
module tb_op_decode_stage;
    localparam int IW  = 11;
    localparam int DW  = 16;
    localparam int OCW = 10 + IW;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           in_valid = 1'b0, flush = 1'b0, out_ready = 1'b0;
    logic [OCW-1:0] op_code = '0;
    logic           in_ready, out_valid;
    logic [3:0]     pc_instr;
    logic [1:0]     alu_instr, registers_instr, in_mux_sel;
    logic           out_mux_sel, port_rd, port_wr, illegal;
    logic [2:0]     src, dst;
    logic [DW-1:0]  imm;

    op_decode_stage #(.IMM_WIDTH(IW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .op_code(op_code), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .pc_instr(pc_instr), .alu_instr(alu_instr), .registers_instr(registers_instr),
        .in_mux_sel(in_mux_sel), .out_mux_sel(out_mux_sel), .src(src), .dst(dst),
        .imm(imm), .port_rd(port_rd), .port_wr(port_wr), .illegal(illegal)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [35:0] sbq[$];      // expected output records, oldest first
    logic        exp_in_ready = 1'b1;
    logic        mon_en = 1'b1;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
        end
    endtask

    function automatic logic [OCW-1:0] mk(input int op, input int s, input int im, input int d);
        logic [3:0] o4 = op[3:0];
        logic [2:0] s3 = s[2:0];
        logic [IW-1:0] i11 = im[IW-1:0];
        logic [2:0] d3 = d[2:0];
        return {o4, s3, i11, d3};
    endfunction

    // Reference decode from the instruction-set rules.
    function automatic logic [35:0] model(input logic [OCW-1:0] w);
        int op = int'(w[OCW-1 -: 4]);
        int s  = int'(w[OCW-5 -: 3]);
        int d  = int'(w[2:0]);
        int iv = int'(w[IW+2:3]);
        int sv, e, alu, rg, im, om, prd, pwr, ill;
        logic [DW-1:0] ext;
        sv  = (iv >= (1 << (IW-1))) ? iv - (1 << IW) : iv;
        ext = DW'(sv);
        ill = (op >= 13) ? 1 : 0;
        e   = ill ? 0 : op;
        alu = (e == 5) ? 1 : (e == 6) ? 2 : 0;
        rg  = (e == 1 || e == 4 || e == 5 || e == 6) ? 1 : (e == 2) ? 2 : (e == 3) ? 3 : 0;
        im  = (s == 0) ? 0 : (s == 1) ? 1 : 2;
        om  = (e == 1) ? 0 : 1;
        prd = (s >= 2) ? 1 : 0;
        pwr = (e == 1 && d >= 2) ? 1 : 0;
        return {e[3:0], alu[1:0], rg[1:0], im[1:0], om[0], s[2:0], d[2:0], ext,
                prd[0], pwr[0], ill[0]};
    endfunction

    function automatic logic [35:0] got_vec();
        return {pc_instr, alu_instr, registers_instr, in_mux_sel, out_mux_sel,
                src, dst, imm, port_rd, port_wr, illegal};
    endfunction

    // Monitor: samples mid-cycle, checks occupancy-derived flags and the
    // head of the scoreboard whenever the DUT presents a word.
    initial forever begin
        @(negedge clk);
        if (!rst && mon_en) begin
            exp_in_ready = (sbq.size() < 2);
            chk("in_ready", 64'(in_ready), 64'(exp_in_ready));
            chk("out_valid", 64'(out_valid), 64'(sbq.size() > 0));
            if (out_valid && sbq.size() > 0) begin
                chk("fields", 64'(got_vec()), 64'(sbq[0]));
                if (out_ready) void'(sbq.pop_front());
            end
        end
    end

    // Drive one cycle; expected result is queued if the word will be taken.
    task automatic cyc(input logic iv, input logic [OCW-1:0] w, input logic ordy, input logic fl);
        @(posedge clk); #2;
        in_valid = iv; op_code = w; out_ready = ordy; flush = fl;
        @(negedge clk); #1;
        if (fl) sbq.delete();
        else if (iv && exp_in_ready) sbq.push_back(model(w));
    endtask

    task automatic do_reset();
        @(posedge clk); #3;
        rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_fields", 64'(got_vec()), 64'd0);
        sbq.delete();
        exp_in_ready = 1'b1;
        @(posedge clk); #2;
        rst = 1'b0;
    endtask

    initial begin
        int maxop;
`ifdef OP_DECODE_ILLEGAL_TRAP_EN
        maxop = 12;
`else
        maxop = 15;
`endif
        repeat (3) @(posedge clk);
        do_reset();

        // MOV ACC -> RIGHT, then ADD NIL with all-ones immediate
        cyc(1, mk(1, 1, 0, 5), 1, 0);
        cyc(1, mk(4, 0, 11'h7FF, 0), 1, 0);
        cyc(0, '0, 1, 0);
        chk("add_imm_sext", 64'(imm), 64'hFFFF);

        // Backpressure: SUB then NEG stalled, then released
        cyc(1, mk(5, 2, 5, 3), 0, 0);
        cyc(1, mk(6, 3, 9, 1), 0, 0);
        cyc(0, '0, 0, 0);
        chk("bp_in_ready_low", 64'(in_ready), 64'd0);
        cyc(0, '0, 0, 0);
        repeat (3) cyc(0, '0, 1, 0);

        // Streaming: 8 back-to-back ops with out_ready high
        for (int i = 0; i < 8; i++)
            cyc(1, mk(i % 13, i % 8, i * 37, 7 - (i % 8)), 1, 0);
        cyc(0, '0, 1, 0);

        // Flush with both entries full and a word offered
        cyc(1, mk(2, 1, 1, 1), 0, 0);
        cyc(1, mk(3, 4, 2, 2), 0, 0);
        cyc(1, mk(7, 5, 3, 3), 0, 1);
        cyc(0, '0, 1, 0);
        chk("flush_out_valid", 64'(out_valid), 64'd0);
        chk("flush_in_ready", 64'(in_ready), 64'd1);

`ifndef OP_DECODE_ILLEGAL_TRAP_EN
        // Illegal opcode passes as a NOP, flow continues
        cyc(1, mk(14, 6, 100, 4), 1, 0);
        cyc(1, mk(1, 0, 4, 2), 1, 0);
        cyc(0, '0, 1, 0);
`endif

        // Randomized traffic
        for (int i = 0; i < 600; i++)
            cyc($urandom_range(0, 3) != 0,
                mk($urandom_range(0, maxop), $urandom_range(0, 7),
                   $urandom_range(0, 2047), $urandom_range(0, 7)),
                $urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0);
        repeat (3) cyc(0, '0, 1, 0);
        chk("drain_empty", 64'(sbq.size()), 64'd0);

        // Asynchronous reset mid-stream with both entries occupied
        cyc(1, mk(4, 1, 1, 1), 0, 0);
        cyc(1, mk(5, 1, 2, 1), 0, 0);
        do_reset();
        repeat (2) cyc(0, '0, 1, 0);

`ifdef OP_DECODE_ILLEGAL_TRAP_EN
        // Trap: illegal word is held with in_ready low until rst
        mon_en = 1'b0;
        cyc(1, mk(14, 0, 0, 0), 1, 0);
        cyc(0, '0, 1, 0);
        chk("trap_illegal", 64'(illegal), 64'd1);
        chk("trap_valid", 64'(out_valid), 64'd1);
        chk("trap_in_ready", 64'(in_ready), 64'd0);
        cyc(1, mk(1, 0, 0, 0), 1, 1);
        cyc(0, '0, 1, 0);
        chk("trap_after_flush_illegal", 64'(illegal), 64'd1);
        chk("trap_after_flush_in_ready", 64'(in_ready), 64'd0);
        do_reset();
        mon_en = 1'b1;
        cyc(0, '0, 1, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
